id_stage_v: RTL
===============

// Module: id_stage_v
// PURPOSE
//  RV32I decode stage; consumes if_stage_v outputs (is_valid/pc/instr) one cycle after fetch.
//  Holds 32x32 register file (WB write port), decodes fields/immediate/control, registers all to EX.
//  Detects load-use hazard and drives is_stall back to IF; honours is_flush by emitting bubbles.
// PARAMETERS
//  NUM_REGS   32  register count (x0 hardwired zero)
//  BYPASS_WB  1   1 = same-cycle WB write visible on read ports; 0 = no bypass
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low (0 = reset)
//  is_flush   in   1   kill instruction entering ID this cycle
//  if_valid   in   1   IF output valid
//  if_pc      in   32  IF pc
//  if_instr   in   32  IF instruction
//  wb_we      in   1   WB write enable
//  wb_rd      in   5   WB destination
//  wb_data    in   32  WB data
//  ex_is_load in   1   instruction currently in EX is a load
//  ex_rd      in   5   EX destination
//  is_stall   out  1   combinational load-use stall to IF
//  id_valid   out  1   registered; EX payload valid
//  id_pc      out  32  registered pc
//  rs1_data   out  32  registered rs1 value
//  rs2_data   out  32  registered rs2 value
//  rs1,rs2,rd out  5   registered register indices
//  imm        out  32  registered sign-extended immediate
//  alu_op     out  4   0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASS_IMM
//  ctrl       out  7   {illegal,is_jalr,is_jal,is_branch,mem_we,mem_re,reg_we}; alu_src_imm implied by opcode
// BEHAVIOUR
//  - Reset (reset=0, async): all registered outputs 0, regfile cleared to 0; is_stall=0 while in reset.
//  - Latency 1: decode of if_instr in cycle N appears on outputs after edge N+1.
//  - Regfile: write on posedge when wb_we && wb_rd!=0; x0 reads 0 always, writes ignored.
//    BYPASS_WB=1: read of wb_rd while wb_we returns wb_data same cycle (rd!=0 only).
//  - Immediate per opcode: I(OP-IMM,LOAD,JALR), S, B, U(LUI,AUIPC), J; bit31 sign-extends; R-type imm=0.
//  - Control: OP/OP-IMM/LUI/AUIPC/JAL/JALR/LOAD -> reg_we; LOAD -> mem_re; STORE -> mem_we; BRANCH -> is_branch, alu_op SUB.
//    LUI -> PASS_IMM; AUIPC/LOAD/STORE/JAL/JALR -> ADD; funct7[5] selects SUB/SRA (SRAI via imm[10]).
//  - Unknown opcode: illegal=1, reg_we/mem_re/mem_we/branch/jump forced 0, id_valid still follows if_valid.
//  - rd forced 0 when reg_we=0 (STORE/BRANCH/illegal).
//  - Hazard: is_stall = if_valid && ex_is_load && ex_rd!=0 && ((uses_rs1 && rs1==ex_rd) || (uses_rs2 && rs2==ex_rd)) && !is_flush.
//    uses_rs1: all but LUI/AUIPC/JAL; uses_rs2: OP/STORE/BRANCH only.
//  - Stall cycle: output registers load bubble (id_valid=0, ctrl=0, other fields don't-care but zeroed);
//    IF holds, same instr re-decoded next cycle.
//  - Flush: id_valid<=0, ctrl<=0 next edge; flush overrides stall and if_valid.
//  - if_valid=0: bubble loaded (id_valid=0, ctrl=0).
//  - Simultaneous WB write and stall: write completes; re-decode sees new value.
//  - Reset mid-operation: all state cleared immediately; first post-reset edge loads whatever IF presents.
// TESTING
//  T1 reset=0 mid-stream -> all outputs 0 async; regfile reads 0 after release.
//  T2 if_instr=0x00500093 (addi x1,x0,5), if_valid=1 -> next cycle rd=1, imm=5, alu_op=0, reg_we=1, id_valid=1.
//  T3 wb_we=1, wb_rd=3, wb_data=0xDEADBEEF with if_instr=0x00018233 (add x4,x3,x0) -> rs1_data=0xDEADBEEF, rd=4.
//  T4 ex_is_load=1, ex_rd=3, if_instr=0x00018233 -> is_stall=1 same cycle, id_valid=0 next; ex_is_load=0 -> id_valid=1.
//  T5 if_instr=0xFE208CE3 (beq x1,x2,-8) -> imm=0xFFFFFFF8, is_branch=1, alu_op=1, rd=0, reg_we=0.
//  T6 is_flush=1 with stall condition true -> is_stall=0, id_valid=0; wb write to x0 -> x0 reads 0.

Source files
------------

// File: rtl/id_stage_v.sv
// -----------------------------------------------------------------------------
// id_stage_v : RV32I instruction decode stage
//
// Sits one cycle behind fetch. Holds the 32x32 integer register file, which
// the writeback stage writes. Decodes the fetched instruction into register
// indices, register operands, a sign-extended immediate, an ALU opcode and
// control flags, and registers all of them towards EX. A load in EX whose
// destination is needed by the decoding instruction produces a combinational
// stall back to IF. A flush turns the decoding instruction into a bubble.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous reset, active low
//   is_flush   in   1   kill the instruction entering ID this cycle
//   if_valid   in   1   IF payload valid
//   if_pc      in  32   IF program counter
//   if_instr   in  32   IF instruction word
//   wb_we      in   1   writeback write enable
//   wb_rd      in   5   writeback destination register
//   wb_data    in  32   writeback data
//   ex_is_load in   1   instruction in EX is a load
//   ex_rd      in   5   destination register of the instruction in EX
//   is_stall   out  1   load-use stall to IF (combinational)
//   id_valid   out  1   EX payload valid (registered)
//   id_pc      out 32   registered pc
//   rs1_data   out 32   registered rs1 operand
//   rs2_data   out 32   registered rs2 operand
//   rs1/rs2/rd out  5   registered register indices (rd is 0 when reg_we=0)
//   imm        out 32   registered sign-extended immediate
//   alu_op     out  4   0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,
//                       8 OR,9 AND,10 PASS_IMM
//   ctrl       out  7   {illegal,is_jalr,is_jal,is_branch,mem_we,mem_re,reg_we}
// -----------------------------------------------------------------------------
module id_stage_v #(
   parameter int NUM_REGS  = 32,
   parameter bit BYPASS_WB = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        is_flush,
   input  logic        if_valid,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_instr,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        ex_is_load,
   input  logic [4:0]  ex_rd,
   output logic        is_stall,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [31:0] imm,
   output logic [3:0]  alu_op,
   output logic [6:0]  ctrl
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   // funct3 -> ALU op. 'alt' is instr[30]; it selects SUB only for register
   // ops (OP-IMM has no SUBI) but selects SRA for both OP and OP-IMM.
   function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt,
                                          input logic allow_sub);
      logic [3:0] op;
      case (f3)
         3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // ---------------- register file ----------------
   logic [31:0] rf_q [NUM_REGS];
   logic        wr_ok;
   logic [4:0]  rs1_idx, rs2_idx;
   logic [31:0] rs1_val, rs2_val;

   assign wr_ok   = wb_we && (wb_rd != 5'd0) && (int'(wb_rd) < NUM_REGS);
   assign rs1_idx = if_instr[19:15];
   assign rs2_idx = if_instr[24:20];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else if (wr_ok) begin
         rf_q[wb_rd] <= wb_data;
      end
   end

   // x0 always reads zero; with bypass a same-cycle write is forwarded.
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1_idx != 5'd0 && int'(rs1_idx) < NUM_REGS) rs1_val = rf_q[rs1_idx];
      if (rs2_idx != 5'd0 && int'(rs2_idx) < NUM_REGS) rs2_val = rf_q[rs2_idx];
      if (BYPASS_WB && wr_ok && wb_rd == rs1_idx) rs1_val = wb_data;
      if (BYPASS_WB && wr_ok && wb_rd == rs2_idx) rs2_val = wb_data;
   end

   // ---------------- decode ----------------
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm_dec;
   logic [3:0]  alu_dec_op;
   logic        reg_we, mem_re, mem_we, is_br, is_jal, is_jalr, illegal;
   logic        uses_rs1, uses_rs2;

   assign opcode = if_instr[6:0];
   assign funct3 = if_instr[14:12];

   always_comb begin
      imm_dec    = '0;
      alu_dec_op = ALU_ADD;
      reg_we     = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      is_br      = 1'b0;
      is_jal     = 1'b0;
      is_jalr    = 1'b0;
      illegal    = 1'b0;
      uses_rs1   = 1'b1;   // only LUI/AUIPC/JAL ignore rs1
      uses_rs2   = 1'b0;
      case (opcode)
         OPC_OP: begin
            reg_we     = 1'b1;
            uses_rs2   = 1'b1;
            alu_dec_op = alu_dec(funct3, if_instr[30], 1'b1);
         end
         OPC_OPIMM: begin
            reg_we     = 1'b1;
            imm_dec    = {{20{if_instr[31]}}, if_instr[31:20]};
            alu_dec_op = alu_dec(funct3, if_instr[30], 1'b0);
         end
         OPC_LOAD: begin
            reg_we  = 1'b1;
            mem_re  = 1'b1;
            imm_dec = {{20{if_instr[31]}}, if_instr[31:20]};
         end
         OPC_STORE: begin
            mem_we   = 1'b1;
            uses_rs2 = 1'b1;
            imm_dec  = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
         end
         OPC_BRANCH: begin
            is_br      = 1'b1;
            uses_rs2   = 1'b1;
            alu_dec_op = ALU_SUB;
            imm_dec    = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                          if_instr[30:25], if_instr[11:8], 1'b0};
         end
         OPC_LUI: begin
            reg_we     = 1'b1;
            uses_rs1   = 1'b0;
            alu_dec_op = ALU_PASS;
            imm_dec    = {if_instr[31:12], 12'd0};
         end
         OPC_AUIPC: begin
            reg_we   = 1'b1;
            uses_rs1 = 1'b0;
            imm_dec  = {if_instr[31:12], 12'd0};
         end
         OPC_JAL: begin
            reg_we   = 1'b1;
            is_jal   = 1'b1;
            uses_rs1 = 1'b0;
            imm_dec  = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                        if_instr[20], if_instr[30:21], 1'b0};
         end
         OPC_JALR: begin
            reg_we  = 1'b1;
            is_jalr = 1'b1;
            imm_dec = {{20{if_instr[31]}}, if_instr[31:20]};
         end
         default: illegal = 1'b1;
      endcase
   end

   // Load-use hazard; suppressed by flush and while reset is asserted.
   assign is_stall = reset && if_valid && ex_is_load && (ex_rd != 5'd0) && !is_flush &&
                     ((uses_rs1 && rs1_idx == ex_rd) || (uses_rs2 && rs2_idx == ex_rd));

   // ---------------- ID/EX register ----------------
   logic        load_en;
   logic        valid_d, valid_q;
   logic [31:0] pc_d, pc_q, rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q, imm_d, imm_q;
   logic [4:0]  rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
   logic [3:0]  alu_d, alu_q;
   logic [6:0]  ctrl_d, ctrl_q;

   assign load_en = if_valid && !is_flush && !is_stall;

   // Anything other than a live instruction loads an all-zero bubble.
   always_comb begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      imm_d      = '0;
      alu_d      = '0;
      ctrl_d     = '0;
      if (load_en) begin
         valid_d    = 1'b1;
         pc_d       = if_pc;
         rs1_data_d = rs1_val;
         rs2_data_d = rs2_val;
         rs1_d      = rs1_idx;
         rs2_d      = rs2_idx;
         rd_d       = reg_we ? if_instr[11:7] : 5'd0;
         imm_d      = imm_dec;
         alu_d      = alu_dec_op;
         ctrl_d     = {illegal, is_jalr, is_jal, is_br, mem_we, mem_re, reg_we};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         imm_q      <= '0;
         alu_q      <= '0;
         ctrl_q     <= '0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         imm_q      <= imm_d;
         alu_q      <= alu_d;
         ctrl_q     <= ctrl_d;
      end
   end

   assign id_valid = valid_q;
   assign id_pc    = pc_q;
   assign rs1_data = rs1_data_q;
   assign rs2_data = rs2_data_q;
   assign rs1      = rs1_q;
   assign rs2      = rs2_q;
   assign rd       = rd_q;
   assign imm      = imm_q;
   assign alu_op   = alu_q;
   assign ctrl     = ctrl_q;

endmodule
